// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//
// Purpose:
//   Bundles the start/done request handshake, the operand inputs and the
//   result outputs of the bit-serial subtractor into one interface.
//
// Handshake semantics:
//   The requester raises start with a, b and bin valid. The request is taken
//   only on a rising clock edge where the subtractor is idle; busy rises right
//   after that edge, so a requester holding start can use busy as its
//   acceptance flag. Operands are don't-care at every other edge. done is a
//   one-cycle pulse meaning diff/bout/ovf were just updated; those three hold
//   their values until the next completion. start seen while busy or done
//   is high is dropped, not queued.
//
// Signals:
//   start  requester -> subtractor  request, sampled only when idle
//   a      requester -> subtractor  minuend (WIDTH bits)
//   b      requester -> subtractor  subtrahend (WIDTH bits)
//   bin    requester -> subtractor  borrow-in
//   busy   subtractor -> requester  high while bits are being processed
//   done   subtractor -> requester  one-cycle completion pulse
//   diff   subtractor -> requester  (a - b - bin) mod 2^WIDTH
//   bout   subtractor -> requester  borrow-out, 1 iff a < b + bin (unsigned)
//   ovf    subtractor -> requester  signed overflow flag
//
// Modports:
//   master  the requesting side
//   slave   the subtractor itself
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start,
    output a,
    output b,
    output bin,
    input  busy,
    input  done,
    input  diff,
    input  bout,
    input  ovf
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  bin,
    output busy,
    output done,
    output diff,
    output bout,
    output ovf
  );

endinterface : serial_subtractor_if

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Purpose:
//   Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, one bit per
//   clock, LSB first. A single full-subtractor cell and a borrow flip-flop do
//   the arithmetic; a three-state FSM (IDLE, RUN, DONE) sequences it.
//
//   Timing, with the request accepted at edge k:
//     edges k+1 .. k+WIDTH  process bits 0 .. WIDTH-1
//     edge  k+WIDTH         results registered, done rises
//     edge  k+WIDTH+1       done falls, back to IDLE
//     edge  k+WIDTH+2       earliest edge a new request is accepted
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   io         serial_subtractor_if.slave (start/a/b/bin in,
//              busy/done/diff/bout/ovf out)
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor_if.slave    io,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;    // minuend, shifted right each RUN edge
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;    // subtrahend, shifted right each RUN edge
  logic [WIDTH-1:0] d_sh_q,   d_sh_d;    // result bits enter at the MSB
  logic             br_q,     br_d;      // running borrow
  logic [CNT_W-1:0] cnt_q,    cnt_d;     // index of the bit being processed
  logic             a_msb_q,  a_msb_d;   // operand sign bits kept for ovf
  logic             b_msb_q,  b_msb_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bout_q,   bout_d;
  logic             ovf_q,    ovf_d;

  // ---------------------------------------------------------------------------
  // Full-subtractor cell on the current LSBs
  // ---------------------------------------------------------------------------
  logic             a0;
  logic             b0;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] d_sh_next;

  always_comb begin
    a0        = a_sh_q[0];
    b0        = b_sh_q[0];
    d_bit     = a0 ^ b0 ^ br_q;
    // Borrow out when a0 < b0, or when the bits are equal and a borrow came in.
    br_next   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    d_sh_next = {d_bit, d_sh_q[WIDTH-1:1]};
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = done_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (io.start) begin
          a_sh_d  = io.a;
          b_sh_d  = io.b;
          d_sh_d  = '0;
          br_d    = io.bin;
          cnt_d   = '0;
          a_msb_d = io.a[WIDTH-1];
          b_msb_d = io.b[WIDTH-1];
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        d_sh_d = d_sh_next;
        br_d   = br_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Last bit: the outputs take the freshly completed word directly,
          // so they change only on this edge.
          cnt_d   = '0;
          diff_d  = d_sh_next;
          bout_d  = br_next;
          // Overflow only possible when operand signs differ; it happened if
          // the result sign disagrees with the minuend sign.
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign io.busy   = busy_q;
  assign io.done   = done_q;
  assign io.diff   = diff_q;
  assign io.bout   = bout_q;
  assign io.ovf    = ovf_q;
  assign dbg_state = state_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Bench for serial_subtractor (WIDTH=8). A transaction-level model predicts
// busy/done/diff/bout/ovf every cycle from plain arithmetic on the accepted
// operands; directed operations additionally compare against literal results.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();
  logic [1:0] dbg_state;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: result = low W bits of {0,a}-{0,b}-bin, borrow = bit W.
  // Timing: outputs appear WIDTH edges after acceptance, done lasts one
  // cycle, and requests are ignored while an operation is in flight.
  // ---------------------------------------------------------------------------
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
    logic [W:0]   full;
    logic [W-1:0] d;
    logic         ov;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    d    = full[W-1:0];
    ov   = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    return {ov, full[W], d};
  endfunction

  logic           m_busy = 1'b0;
  logic           m_done = 1'b0;
  logic [W-1:0]   m_diff = '0;
  logic           m_bout = 1'b0;
  logic           m_ovf  = 1'b0;
  logic [W+1:0]   m_pend = '0;
  int             m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_diff <= '0;
      m_bout <= 1'b0;
      m_ovf  <= 1'b0;
      m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        {m_ovf, m_bout, m_diff} <= m_pend;
      end
    end else if (bus.start) begin
      m_pend <= ref_sub(bus.a, bus.b, bus.bin);
      m_left <= W;
      m_busy <= 1'b1;
    end
  end

  // Continuous compare, sampled on the falling edge.
  always @(negedge clk) begin
    check("busy", bus.busy, m_busy);
    check("done", bus.done, m_done);
    check("diff", bus.diff, m_diff);
    check("bout", bus.bout, m_bout);
    check("ovf",  bus.ovf,  m_ovf);
    check("busy_done_excl", bus.busy & bus.done, 0);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1)
  // ---------------------------------------------------------------------------
  // Raise start and wait until it is accepted; returns edges waited.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output int waited);
    bit acc;
    acc       = 1'b0;
    waited    = 0;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    while (!acc && waited < 6) begin
      @(posedge clk);
      #1;
      waited++;
      if (bus.busy) acc = 1'b1;
    end
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom_range(0, 1));
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  // Wait for done; lat counts edges since acceptance (starting at lat0).
  task automatic wait_done(input int lat0, output int lat, output int nbusy);
    lat   = lat0;
    nbusy = 1;
    while (!bus.done && lat < W + 6) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) nbusy++;
    end
  endtask

  task automatic op_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic bin, input logic [W-1:0] ed, input logic eb,
                             input logic eo);
    int wt, lat, nb;
    start_op(a, b, bin, wt);
    wait_done(0, lat, nb);
    check({name, "_latency"}, lat, W);
    check({name, "_diff"}, bus.diff, ed);
    check({name, "_bout"}, bus.bout, eb);
    check({name, "_ovf"},  bus.ovf,  eo);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [W-1:0] corners [4];

  initial begin
    int wt, lat, nb, cnt_done;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    corners[0] = 8'h00; corners[1] = 8'hFF; corners[2] = 8'h7F; corners[3] = 8'h80;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_bout", bus.bout, 0);
    check("rst_ovf",  bus.ovf,  0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First op: latency and busy duration.
    start_op(8'h05, 8'h03, 1'b0, wt);
    wait_done(0, lat, nb);
    check("first_latency", lat, W);
    check("first_busy_cycles", nb, W);
    check("first_diff", bus.diff, 8'h02);
    check("first_bout", bus.bout, 0);
    check("first_ovf",  bus.ovf,  0);

    // Back-to-back: start raised in the done cycle, accepted two edges later.
    start_op(8'h03, 8'h05, 1'b0, wt);
    check("b2b_accept_edges", wt, 2);
    wait_done(0, lat, nb);
    check("b2b_diff", bus.diff, 8'hFE);
    check("b2b_bout", bus.bout, 1);
    check("b2b_ovf",  bus.ovf,  0);

    op_directed("zero_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    op_directed("neg_ovf",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    op_directed("pos_ovf",  8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Start pulsed during RUN is ignored.
    start_op(8'h40, 8'h11, 1'b0, wt);
    repeat (2) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02; bus.bin = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(3, lat, nb);
    check("ignore_latency", lat, W);
    check("ignore_diff", bus.diff, 8'h2F);
    check("ignore_bout", bus.bout, 0);
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN.
    start_op(8'h33, 8'h11, 1'b0, wt);
    repeat (3) @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_diff", bus.diff, 0);
    check("arst_bout", bus.bout, 0);
    check("arst_ovf",  bus.ovf,  0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt_done = 0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (bus.done) cnt_done++;
    end
    check("arst_no_done", cnt_done, 0);
    op_directed("post_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    // Exhaustive corners.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 2; k++) begin
          start_op(corners[i], corners[j], 1'(k), wt);
          wait_done(0, lat, nb);
          check("corner_latency", lat, W);
        end

    // Random operations with random stray starts and idle gaps.
    for (int n = 0; n < 1000; n++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), wt);
      bus.start = ($urandom_range(0, 3) == 0);
      wait_done(0, lat, nb);
      check("rand_latency", lat, W);
      bus.start = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_subtractor
